// File: rtl/bcd2binary_reverse_dabble.sv
// Packed-BCD to binary converter using reverse double-dabble.
// Each cycle in CONV shifts the {bcd, binary} register right by one bit, then
// subtracts 3 from every BCD digit that is now >= 8. After BIN_WIDTH shifts the
// binary field holds the value. Input words with a digit > 9 are flagged as errors
// and are not converted.
module bcd2binary_reverse_dabble #(
  parameter int unsigned DIGITS    = 3,
  parameter int unsigned BIN_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_WIDTH-1:0]  out_binary,
  output logic                  out_err
);

  localparam int unsigned BcdW  = 4 * DIGITS;
  localparam int unsigned WorkW = BcdW + BIN_WIDTH;
  localparam int unsigned CntW  = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e               state_q, state_d;
  logic [BcdW-1:0]      bcd_q, bcd_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BIN_WIDTH-1:0] out_binary_q, out_binary_d;
  logic                 out_err_q, out_err_d;

  logic [WorkW-1:0]     shifted;
  logic [BcdW-1:0]      bcd_fix;
  logic [BIN_WIDTH-1:0] bin_sh;
  logic                 illegal;
  logic                 last_iter;

  // One reverse-dabble step: shift right, then correct each digit independently.
  always_comb begin
    shifted = {bcd_q, bin_q} >> 1;
    bin_sh  = shifted[BIN_WIDTH-1:0];
    bcd_fix = shifted[WorkW-1 -: BcdW];
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_fix[4*i +: 4] >= 4'd8) begin
        bcd_fix[4*i +: 4] = bcd_fix[4*i +: 4] - 4'd3;
      end
    end
  end

  // Flag any input nibble outside 0..9.
  always_comb begin
    illegal = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (in_bcd[4*i +: 4] > 4'd9) begin
        illegal = 1'b1;
      end
    end
  end

  assign last_iter = (cnt_q == CntW'(BIN_WIDTH - 1));

  // Next-state and datapath control.
  always_comb begin
    state_d      = state_q;
    bcd_d        = bcd_q;
    bin_d        = bin_q;
    cnt_d        = cnt_q;
    out_binary_d = out_binary_q;
    out_err_d    = out_err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (illegal) begin
            out_binary_d = '0;
            out_err_d    = 1'b1;
            state_d      = StDone;
          end else begin
            bcd_d   = in_bcd;
            bin_d   = '0;
            cnt_d   = '0;
            state_d = StConv;
          end
        end
      end
      StConv: begin
        bcd_d = bcd_fix;
        bin_d = bin_sh;
        cnt_d = cnt_q + CntW'(1);
        if (last_iter) begin
          out_binary_d = bin_sh;
          out_err_d    = 1'b0;
          state_d      = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset abandons any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      bcd_q        <= '0;
      bin_q        <= '0;
      cnt_q        <= '0;
      out_binary_q <= '0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bcd_q        <= bcd_d;
      bin_q        <= bin_d;
      cnt_q        <= cnt_d;
      out_binary_q <= out_binary_d;
      out_err_q    <= out_err_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign out_binary = out_binary_q;
  assign out_err    = out_err_q;

  // A legal word must leave no residue in the BCD field after the last shift.
  a_bcd_drained: assert property (@(posedge clk) disable iff (rst)
    (state_q == StConv && last_iter) |-> (bcd_fix == '0));

endmodule
